// File: rtl/mouse_display_mux.sv
// mouse_display_mux: drives Sseg_Dev from ps2_mouse_driver data.
// Generates its own refresh start pulse, offers four display pages selected by a
// debounced pushbutton, supports freezing the display, and keeps wrapping click
// counters with sticky overflow flags plus running min/max of the pointer position.
module mouse_display_mux #(
    parameter int POS_W       = 10,
    parameter int CNT_W       = 16,
    parameter int REFRESH_DIV = 2097152,
    parameter int DB_CYCLES   = 1000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [POS_W-1:0] x_pos,
    input  logic [POS_W-1:0] y_pos,
    input  logic             left_btn,
    input  logic             right_btn,
    input  logic             page_btn,
    input  logic             freeze,
    input  logic             clear,
    output logic             start,
    output logic [31:0]      hexs,
    output logic [7:0]       points,
    output logic [7:0]       LEs,
    output logic [1:0]       page,
    output logic [1:0]       ovf
);

    localparam int             RW     = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0]  R_LAST = RW'(REFRESH_DIV - 1);
    localparam int             DW     = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0]  D_LAST = DW'(DB_CYCLES - 1);

    logic [RW-1:0]    ref_cnt;
    logic             load;
    logic             left_prev;
    logic             right_prev;
    logic             left_rise;
    logic             right_rise;
    logic [CNT_W-1:0] left_cnt;
    logic [CNT_W-1:0] right_cnt;
    logic [POS_W-1:0] xmax;
    logic [POS_W-1:0] ymax;
    logic [POS_W-1:0] xmin;
    logic [POS_W-1:0] ymin;
    logic             pb_s1;
    logic             pb_s2;
    logic             db_level;
    logic [DW-1:0]    db_cnt;
    logic [31:0]      page_word;

    assign LEs        = 8'h00;
    assign load       = (ref_cnt == R_LAST);
    assign left_rise  = left_btn & ~left_prev;
    assign right_rise = right_btn & ~right_prev;

    // Free-running refresh divider; start fires on the edge where the count wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_cnt <= '0;
            start   <= 1'b0;
        end else begin
            start   <= load;
            ref_cnt <= load ? '0 : ref_cnt + RW'(1);
        end
    end

    // Display word and decimal points are captured with start unless frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hexs   <= '0;
            points <= '0;
        end else if (load && !freeze) begin
            hexs   <= page_word;
            points <= 8'h01 << page;
        end
    end

    // Select the display content for the current page, fields zero-extended.
    always_comb begin
        page_word = '0;
        case (page)
            2'd0:    page_word = {3'b0, left_btn, 3'b0, right_btn, 12'(x_pos), 12'(y_pos)};
            2'd1:    page_word = {16'(left_cnt), 16'(right_cnt)};
            2'd2:    page_word = {4'b0, 12'(xmax), 4'b0, 12'(ymax)};
            default: page_word = {4'b0, 12'(xmin), 4'b0, 12'(ymin)};
        endcase
    end

    // Click counters wrap; overflow flags stick until clear, which also drops a coincident edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            left_prev  <= 1'b0;
            right_prev <= 1'b0;
            left_cnt   <= '0;
            right_cnt  <= '0;
            ovf        <= 2'b00;
        end else begin
            left_prev  <= left_btn;
            right_prev <= right_btn;
            if (clear) begin
                left_cnt  <= '0;
                right_cnt <= '0;
                ovf       <= 2'b00;
            end else begin
                if (left_rise) begin
                    left_cnt <= left_cnt + CNT_W'(1);
                    if (&left_cnt) ovf[0] <= 1'b1;
                end
                if (right_rise) begin
                    right_cnt <= right_cnt + CNT_W'(1);
                    if (&right_cnt) ovf[1] <= 1'b1;
                end
            end
        end
    end

    // Running extremes of the pointer position; clear restarts them and ignores that cycle's sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || clear) begin
            xmax <= '0;
            ymax <= '0;
            xmin <= '1;
            ymin <= '1;
        end else begin
            if (x_pos > xmax) xmax <= x_pos;
            if (y_pos > ymax) ymax <= y_pos;
            if (x_pos < xmin) xmin <= x_pos;
            if (y_pos < ymin) ymin <= y_pos;
        end
    end

    // Two-flop synchroniser for the asynchronous page pushbutton.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pb_s1 <= 1'b0;
            pb_s2 <= 1'b0;
        end else begin
            pb_s1 <= page_btn;
            pb_s2 <= pb_s1;
        end
    end

    // Debounce: a new level is accepted after DB_CYCLES consecutive differing samples; presses advance the page.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            page     <= 2'd0;
        end else if (pb_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == D_LAST) begin
            db_level <= pb_s2;
            db_cnt   <= '0;
            if (pb_s2) page <= page + 2'd1;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

endmodule

// File: tb/tb_mouse_display_mux.sv
// Directed testbench for mouse_display_mux with a scoreboard of expected display loads.
module tb_mouse_display_mux;

    localparam int POS_W       = 10;
    localparam int CNT_W       = 4;
    localparam int REFRESH_DIV = 16;
    localparam int DB_CYCLES   = 4;

    typedef struct packed {
        logic [31:0] hexs;
        logic [7:0]  points;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [POS_W-1:0] x_pos;
    logic [POS_W-1:0] y_pos;
    logic             left_btn;
    logic             right_btn;
    logic             page_btn;
    logic             freeze;
    logic             clear;
    logic             start;
    logic [31:0]      hexs;
    logic [7:0]       points;
    logic [7:0]       LEs;
    logic [1:0]       page;
    logic [1:0]       ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mouse_display_mux #(
        .POS_W(POS_W), .CNT_W(CNT_W), .REFRESH_DIV(REFRESH_DIV), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .x_pos(x_pos), .y_pos(y_pos),
        .left_btn(left_btn), .right_btn(right_btn), .page_btn(page_btn),
        .freeze(freeze), .clear(clear), .start(start), .hexs(hexs),
        .points(points), .LEs(LEs), .page(page), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] h, input logic [7:0] p);
        exp_t e;
        e.hexs   = h;
        e.points = p;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_output({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_output({tag, "_hexs"}, hexs, e.hexs);
            check_output({tag, "_points"}, {24'd0, points}, {24'd0, e.points});
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (start !== 1'b1 && n < 4 * REFRESH_DIV);
        if (start !== 1'b1) check_output({tag, "_start_timeout"}, 32'd0, 32'd1);
        else pop_compare(tag);
    endtask

    task automatic apply_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_left(input int n);
        repeat (n) begin
            left_btn = 1'b1;
            @(negedge clk);
            left_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic apply_right(input int n);
        repeat (n) begin
            right_btn = 1'b1;
            @(negedge clk);
            right_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic apply_page(input int hold);
        page_btn = 1'b1;
        repeat (hold) @(negedge clk);
        page_btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rstn      = 1'b0;
        x_pos     = 10'h123;
        y_pos     = 10'h2AB;
        left_btn  = 1'b1;
        right_btn = 1'b0;
        page_btn  = 1'b0;
        freeze    = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_hexs", hexs, 32'h0);
        check_output("rst_points", {24'd0, points}, 32'h0);
        check_output("rst_start", {31'd0, start}, 32'h0);
        check_output("rst_page", {30'd0, page}, 32'h0);
        check_output("rst_ovf", {30'd0, ovf}, 32'h0);
        check_output("rst_les", {24'd0, LEs}, 32'h0);

        // refresh cadence and page 0 format
        repeat (3) push_expect(32'h1012_32AB, 8'h01);
        rstn = 1'b1;
        for (int n = 1; n <= 3 * REFRESH_DIV; n++) begin
            @(negedge clk);
            check_output($sformatf("start_c%0d", n), {31'd0, start}, {31'd0, (n % REFRESH_DIV) == 0});
            if (start === 1'b1) pop_compare("page0_live");
        end

        // glitch rejection, click counts, page 1
        left_btn = 1'b0;
        apply_clear();
        apply_page(3);
        check_output("glitch_page", {30'd0, page}, 32'd0);
        apply_left(3);
        apply_right(5);
        apply_page(6);
        check_output("press_page", {30'd0, page}, 32'd1);
        check_output("cnt_ovf", {30'd0, ovf}, 32'd0);
        push_expect(32'h0003_0005, 8'h02);
        wait_start("page1_counts");

        // counter wrap and sticky overflow, then clear beating an edge
        apply_clear();
        apply_left(17);
        check_output("wrap_ovf", {30'd0, ovf}, 32'd1);
        push_expect(32'h0001_0000, 8'h02);
        wait_start("page1_wrap");
        left_btn = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        left_btn = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        check_output("clear_ovf", {30'd0, ovf}, 32'd0);
        push_expect(32'h0000_0000, 8'h02);
        wait_start("page1_cleared");

        // back to page 0, then freeze
        repeat (3) apply_page(6);
        check_output("wrap_page", {30'd0, page}, 32'd0);
        push_expect(32'h0012_32AB, 8'h01);
        wait_start("page0_prefreeze");
        freeze = 1'b1;
        x_pos  = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            push_expect(32'h0012_32AB, 8'h01);
            wait_start($sformatf("frozen%0d", i));
        end
        freeze = 1'b0;
        push_expect(32'h003F_F2AB, 8'h01);
        wait_start("unfrozen");

        // min/max tracking on pages 2 and 3
        x_pos = 10'd5;
        y_pos = 10'd7;
        apply_clear();
        x_pos = 10'd300;
        @(negedge clk);
        x_pos = 10'd40;
        @(negedge clk);
        repeat (2) apply_page(6);
        check_output("max_page", {30'd0, page}, 32'd2);
        push_expect(32'h012C_0007, 8'h04);
        wait_start("page2_max");
        apply_page(6);
        check_output("min_page", {30'd0, page}, 32'd3);
        push_expect(32'h0005_0007, 8'h08);
        wait_start("page3_min");

        // asynchronous reset mid-period and full-period restart
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_output("mid_rst_hexs", hexs, 32'h0);
        check_output("mid_rst_points", {24'd0, points}, 32'h0);
        check_output("mid_rst_start", {31'd0, start}, 32'h0);
        check_output("mid_rst_page", {30'd0, page}, 32'h0);
        check_output("mid_rst_ovf", {30'd0, ovf}, 32'h0);
        @(negedge clk);
        push_expect(32'h0002_8007, 8'h01);
        rstn = 1'b1;
        for (int n = 1; n <= REFRESH_DIV; n++) begin
            @(negedge clk);
            check_output($sformatf("restart_c%0d", n), {31'd0, start}, {31'd0, n == REFRESH_DIV});
            if (start === 1'b1) pop_compare("restart_load");
        end
        check_output("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
